// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models mult/div latency
// with a down-counter and raises the D-stage stall for dependent MD instructions.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic          pwe_q, pwe_d;
  logic          busy_q, busy_d;

  // Operands sign-extended to 64 bits so the -2^31 / -1 corner wraps cleanly.
  logic signed [63:0] a_sx, b_sx;
  logic        [63:0] prod_s, prod_u;
  logic        [31:0] q_s, r_s, q_u, r_u;
  logic               is_long_op;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign q_s    = 32'(a_sx / b_sx);
  assign r_s    = 32'(a_sx % b_sx);
  assign q_u    = A / B;
  assign r_u    = A % B;

  assign is_long_op = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwe_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwe_q   <= pwe_d;
      busy_q  <= busy_d;
    end
  end

  // Issue in IDLE, count down in RUN, commit pending result on the last edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwe_d   = pwe_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT: begin
              phi_d   = prod_s[63:32];
              plo_d   = prod_s[31:0];
              pwe_d   = 1'b1;
              count_d = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_MULTU: begin
              phi_d   = prod_u[63:32];
              plo_d   = prod_u[31:0];
              pwe_d   = 1'b1;
              count_d = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV: begin
              phi_d   = r_s;
              plo_d   = q_s;
              pwe_d   = (B != 32'd0);
              count_d = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_DIVU: begin
              phi_d   = r_u;
              plo_d   = q_u;
              pwe_d   = (B != 32'd0);
              count_d = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = IDLE;
          if (pwe_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_comb begin
    rd = '0;
    if (mdu_op == OP_MFHI)
      rd = hi_q;
    else if (mdu_op == OP_MFLO)
      rd = lo_q;
  end

  assign stall = d_is_md & (busy_q | (start & is_long_op));
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed test-plan steps followed by random traffic, all
// checked against an arithmetic reference model of HI/LO and busy latency.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] A, B;
  logic        d_is_md;
  logic        busy, stall;
  logic [31:0] hi, lo, rd;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .A(A), .B(B),
    .d_is_md(d_is_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo), .rd(rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  logic        m_we = 0;
  int          m_left = 0;
  logic        last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst_n, input logic st, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] p;
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_we = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_we) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end else if (st) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      case (op)
        4'd1: begin p = 64'(x * y); m_phi = p[63:32]; m_plo = p[31:0]; m_we = 1; m_left = 5; end
        4'd2: begin p = {32'd0, a} * {32'd0, b}; m_phi = p[63:32]; m_plo = p[31:0]; m_we = 1; m_left = 5; end
        4'd3: begin
          m_we = (b != 0); m_left = 10;
          if (b != 0) begin q = x / y; r = x % y; m_plo = 32'(q); m_phi = 32'(r); end
        end
        4'd4: begin
          m_we = (b != 0); m_left = 10;
          if (b != 0) begin m_plo = a / b; m_phi = a % b; end
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // One clock cycle: check combinational outputs before the edge, registered after.
  task automatic step(input logic st, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic dmd);
    logic exp_stall;
    logic [31:0] exp_rd;
    start = st; mdu_op = op; A = a; B = b; d_is_md = dmd;
    #2;
    exp_stall = dmd & ((m_left > 0) | (st & (op >= 4'd1) & (op <= 4'd4)));
    exp_rd = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    chk("rd", rd, exp_rd);
    last_stall = stall;
    @(posedge clk);
    model_edge(reset, st, op, a, b);
    #1;
    chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    end
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    reset = 1'b0; start = 0; mdu_op = 0; A = 0; B = 0; d_is_md = 0;
    step(0, 4'd0, 0, 0, 0);
    step(1, 4'd5, 32'h1111_1111, 0, 1);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    step(0, 4'd0, 0, 0, 0);
    chk("idle_stall", {31'd0, stall}, 32'd0);

    // mult / multu with -2 * 3
    step(1, 4'd1, 32'hFFFF_FFFE, 32'd3, 0);
    count_busy(n);
    chk("mult_busy_len", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    step(1, 4'd2, 32'hFFFF_FFFE, 32'd3, 0);
    count_busy(n);
    chk("multu_busy_len", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    // div -7 / 2, then divu by zero
    step(1, 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
    count_busy(n);
    chk("div_busy_len", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    step(1, 4'd4, 32'd7, 32'd0, 0);
    count_busy(n);
    chk("divz_busy_len", 32'(n), 32'd10);
    chk("divz_hi", hi, 32'hFFFF_FFFF);
    chk("divz_lo", lo, 32'hFFFF_FFFD);

    // mthi / mtlo back to back, then reads
    step(1, 4'd5, 32'h1234_5678, 0, 0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    step(1, 4'd6, 32'h9ABC_DEF0, 0, 0);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    step(0, 4'd7, 0, 0, 0);
    chk("mfhi_rd", rd, 32'h1234_5678);
    step(0, 4'd8, 0, 0, 0);
    chk("mflo_rd", rd, 32'h9ABC_DEF0);

    // stall window with d_is_md held high
    n = 0;
    step(1, 4'd1, 32'd6, 32'd7, 1);
    if (last_stall === 1'b1) n++;
    for (int i = 0; i < 6; i++) begin
      step(0, 4'd0, 0, 0, 1);
      if (last_stall === 1'b1) n++;
    end
    chk("stall_len", 32'(n), 32'd6);
    chk("stall_after", {31'd0, last_stall}, 32'd0);
    n = 0;
    step(1, 4'd1, 32'd6, 32'd7, 0);
    if (last_stall === 1'b1) n++;
    for (int i = 0; i < 6; i++) begin
      step(0, 4'd0, 0, 0, 0);
      if (last_stall === 1'b1) n++;
    end
    chk("nostall_len", 32'(n), 32'd0);

    // mthi issued during a mult run is ignored
    step(1, 4'd1, 32'd100, 32'd200, 0);
    step(1, 4'd5, 32'hDEAD_BEEF, 0, 0);
    count_busy(n);
    chk("ign_busy_len", 32'(n + 1), 32'd5);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd20000);

    // reset in busy cycle 4 of a div abandons it
    step(1, 4'd5, 32'h5555_AAAA, 0, 0);
    step(1, 4'd3, 32'd1000, 32'd7, 0);
    for (int i = 0; i < 3; i++) step(0, 4'd0, 0, 0, 0);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    step(0, 4'd0, 0, 0, 0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    reset = 1'b1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 60) != 0);
      rop = 4'($urandom_range(0, 15));
      ra = $urandom();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      step(1'($urandom_range(0, 1)), rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
